// File: rtl/lsu_queue_pkg.sv
// lsu_queue_pkg: shared definitions for the LSU request queue.
//   - op parameter (para) field layout and width
//   - default data/address and register-index widths
//   - misalignment helper used when LSQ_MISALIGN_CHECK_EN is defined
// Entry packing order (MSB..LSB): {misalign, rd, wdata, addr, para};
// the misalign field only exists when LSQ_MISALIGN_CHECK_EN is defined.
package lsu_queue_pkg;
  localparam int PARA_W       = 4;
  localparam int SIZE_LSB     = 0;  // [1:0] log2 access size
  localparam int UNSIGNED_BIT = 2;  // zero-extend load
  localparam int STORE_BIT    = 3;  // 1 = store, 0 = load
  localparam int LSQ_XLEN     = 32;
  localparam int LSQ_RD_W     = 5;

  // Low address bits must be zero for the access size (1/2/4/8 bytes).
  function automatic logic is_misaligned(input logic [PARA_W-1:0] para,
                                         input logic [2:0]        addr_lo);
    logic [2:0] mask;
    mask = (3'b001 << para[SIZE_LSB +: 2]) - 3'd1;
    return |(addr_lo & mask);
  endfunction
endpackage

// File: rtl/lsq_ptr_ctl.sv
// lsq_ptr_ctl: pointer and occupancy bookkeeping for lsu_queue.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   clr_i         flush: pointers and counters to zero
//   enq_i         write entry at tail
//   iss_i         entry at iss sent to LSU (iss++, out++)
//   ret_i         issued entry at head retired (head++, cnt--, out--)
//   skip_i        unissued entry at head==iss retired without issue
//   tail_o/iss_o/head_o  pointers (wrap modulo DEPTH)
//   cnt_o         entries held, out_o entries issued but not retired
//   full_o/empty_o occupancy flags
module lsq_ptr_ctl #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          enq_i,
  input  logic          iss_i,
  input  logic          ret_i,
  input  logic          skip_i,
  output logic [AW-1:0] tail_o,
  output logic [AW-1:0] iss_o,
  output logic [AW-1:0] head_o,
  output logic [AW:0]   cnt_o,
  output logic [AW:0]   out_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [AW-1:0] tail_q, tail_d, iss_q, iss_d, head_q, head_d;
  logic [AW:0]   cnt_q, cnt_d, out_q, out_d;

  // DEPTH is a power of two, so pointer increments wrap for free.
  always_comb begin
    tail_d = tail_q + AW'(enq_i);
    iss_d  = iss_q  + AW'(iss_i | skip_i);
    head_d = head_q + AW'(ret_i | skip_i);
    cnt_d  = cnt_q + (AW+1)'(enq_i) - (AW+1)'(ret_i) - (AW+1)'(skip_i);
    out_d  = out_q + (AW+1)'(iss_i) - (AW+1)'(ret_i);
  end

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      tail_q <= '0;
      iss_q  <= '0;
      head_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      tail_q <= tail_d;
      iss_q  <= iss_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign tail_o  = tail_q;
  assign iss_o   = iss_q;
  assign head_o  = head_q;
  assign cnt_o   = cnt_q;
  assign out_o   = out_q;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/lsu_queue.sv
// lsu_queue: in-order memory-op queue in front of the load/store unit.
// Accepts ops from execute, issues them one at a time to the LSU, pops LSU
// results in order and presents a registered retire to writeback. An error
// result freezes issue and enqueue (lsq_halt) until clear_pipeline/reset.
// Ports:
//   clk, rst (sync, active-low), clear_pipeline (flush)
//   in_*   : op input (vld/rdy handshake, para/addr/wdata/rd)
//   lsu_*  : request out (initial/para/addr/wdata, ready in),
//            result in (finished/status/rdata, ack out)
//   wb_*   : registered retire (vld/we/rd/data/err)
//   lsq_halt, lsq_empty : status
// Optional: LSQ_MISALIGN_CHECK_EN flags misaligned ops at enqueue; such an
// op is never issued and retires with wb_err once all older ops retired.
module lsu_queue
  import lsu_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = LSQ_XLEN,
  parameter int RD_W  = LSQ_RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_pipeline,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [PARA_W-1:0] in_para,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              lsu_initial,
  output logic [PARA_W-1:0] lsu_para,
  output logic [XLEN-1:0]   lsu_addr,
  output logic [XLEN-1:0]   lsu_wdata,
  input  logic              lsu_ready,
  input  logic              lsu_finished,
  input  logic              lsu_status,
  input  logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_ack,
  output logic              wb_vld,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_err,
  output logic              lsq_halt,
  output logic              lsq_empty
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
`ifdef LSQ_MISALIGN_CHECK_EN
    logic              misalign;
`endif
    logic [RD_W-1:0]   rd;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   addr;
    logic [PARA_W-1:0] para;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] tail, iss, head;
  logic [AW:0]   cnt, out;
  logic          full, empty;
  logic          halt_q;
  logic          enq, fire, skip, iss_blk;
  logic          wb_vld_q, wb_we_q, wb_err_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  lsq_ptr_ctl #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clear_pipeline),
    .enq_i  (enq),
    .iss_i  (fire),
    .ret_i  (lsu_ack),
    .skip_i (skip),
    .tail_o (tail),
    .iss_o  (iss),
    .head_o (head),
    .cnt_o  (cnt),
    .out_o  (out),
    .full_o (full),
    .empty_o(empty)
  );

`ifdef LSQ_MISALIGN_CHECK_EN
  // A flagged op at iss blocks issue; once nothing older is in flight
  // (out==0, so head==iss) it retires directly as a fault.
  assign iss_blk = mem_q[iss].misalign;
  assign skip    = mem_q[head].misalign & (out == '0) & ~empty & ~halt_q
                 & ~clear_pipeline;
`else
  assign iss_blk = 1'b0;
  assign skip    = 1'b0;
`endif

  // in_rdy uses registered occupancy only, so a same-cycle retire never
  // makes room for a same-cycle enqueue.
  assign in_rdy      = ~full & ~halt_q;
  assign enq         = in_vld & in_rdy & ~clear_pipeline;
  assign lsu_initial = (cnt > out) & ~halt_q & ~iss_blk;
  assign fire        = lsu_initial & lsu_ready & ~clear_pipeline;
  assign lsu_ack     = lsu_finished & (out != '0) & ~clear_pipeline;

  // iss only moves on fire, and tail can only reach iss's slot when no
  // unissued entry exists, so the payload holds while lsu_initial is high.
  assign lsu_para  = mem_q[iss].para;
  assign lsu_addr  = mem_q[iss].addr;
  assign lsu_wdata = mem_q[iss].wdata;

  always_ff @(posedge clk) begin
    if (enq) begin
`ifdef LSQ_MISALIGN_CHECK_EN
      mem_q[tail].misalign <= is_misaligned(in_para, in_addr[2:0]);
`endif
      mem_q[tail].rd    <= in_rd;
      mem_q[tail].wdata <= in_wdata;
      mem_q[tail].addr  <= in_addr;
      mem_q[tail].para  <= in_para;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear_pipeline)     halt_q <= 1'b0;
    else if ((lsu_ack & lsu_status) | skip) halt_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_vld_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_err_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      wb_vld_q <= lsu_ack | skip;
      if (lsu_ack) begin
        wb_rd_q   <= mem_q[head].rd;
        wb_data_q <= mem_q[head].para[STORE_BIT] ? '0 : lsu_rdata;
        wb_err_q  <= lsu_status;
        wb_we_q   <= ~mem_q[head].para[STORE_BIT] & (mem_q[head].rd != '0)
                   & ~lsu_status;
      end else if (skip) begin
        wb_rd_q   <= mem_q[head].rd;
        wb_data_q <= '0;
        wb_err_q  <= 1'b1;
        wb_we_q   <= 1'b0;
      end
    end
  end

  assign wb_vld    = wb_vld_q;
  assign wb_we     = wb_we_q;
  assign wb_err    = wb_err_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign lsq_halt  = halt_q;
  assign lsq_empty = empty;
endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: randomized bench for lsu_queue. The reference keeps the
// queue as a list of ops plus an issued count; a small LSU model returns
// results in request order.
module tb_lsu_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int RD_W  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clear_pipeline = 1'b0;
  logic            in_vld = 1'b0;
  logic            in_rdy;
  logic [3:0]      in_para = '0;
  logic [XLEN-1:0] in_addr = '0, in_wdata = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic            lsu_initial;
  logic [3:0]      lsu_para;
  logic [XLEN-1:0] lsu_addr, lsu_wdata;
  logic            lsu_ready = 1'b0, lsu_finished = 1'b0, lsu_status = 1'b0;
  logic [XLEN-1:0] lsu_rdata = '0;
  logic            lsu_ack;
  logic            wb_vld, wb_we, wb_err, lsq_halt, lsq_empty;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  lsu_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .clear_pipeline(clear_pipeline),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_para(in_para), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .lsu_initial(lsu_initial), .lsu_para(lsu_para), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready), .lsu_finished(lsu_finished),
    .lsu_status(lsu_status), .lsu_rdata(lsu_rdata), .lsu_ack(lsu_ack),
    .wb_vld(wb_vld), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .lsq_halt(lsq_halt), .lsq_empty(lsq_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      para;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [RD_W-1:0] rd;
  } op_t;
  typedef struct {
    logic [XLEN-1:0] rdata;
    logic            st;
  } res_t;

  op_t  mq[$];     // ops held, oldest first; the first n_iss are issued
  res_t lsu_q[$];  // results the LSU model will hand back, in order
  int   n_iss = 0;
  bit   halt_m = 0;
  bit   e_vld = 0, e_we = 0, e_err = 0, e_rst = 0;
  logic [RD_W-1:0] e_rd = '0;
  logic [XLEN-1:0] e_data = '0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit mis(input op_t o);
    int sz;
    sz = 1 << o.para[1:0];
    return (o.addr % sz) != 0;
  endfunction

  task automatic step(input int p_vld, input int p_rdy, input int p_fin,
                      input int p_err, input int p_clr, input int p_rst,
                      input int p_spur);
    op_t  o;
    res_t r;
    bit   e_rdy, e_init, e_ack, skip, fire, is_st;
    @(negedge clk);
    rst            = !($urandom_range(99) < p_rst);
    clear_pipeline = $urandom_range(99) < p_clr;
    in_vld         = $urandom_range(99) < p_vld;
    in_para        = 4'($urandom);
    in_addr        = $urandom;
    in_wdata       = $urandom;
    in_rd          = ($urandom_range(3) == 0) ? '0 : RD_W'($urandom);
    lsu_ready      = $urandom_range(99) < p_rdy;
    if (lsu_q.size() > 0) begin
      lsu_finished = $urandom_range(99) < p_fin;
      lsu_rdata    = lsu_q[0].rdata;
      lsu_status   = lsu_q[0].st;
    end else begin
      lsu_finished = $urandom_range(99) < p_spur;
      lsu_rdata    = $urandom;
      lsu_status   = 1'($urandom);
    end
    #1;
    chk("wb_vld", wb_vld, e_vld);
    if (e_vld || e_rst) begin
      chk("wb_we", wb_we, e_we);
      chk("wb_rd", wb_rd, e_rd);
      chk("wb_data", wb_data, e_data);
      chk("wb_err", wb_err, e_err);
    end

    e_rdy  = mq.size() < DEPTH && !halt_m;
    e_init = mq.size() > n_iss && !halt_m;
    skip   = 0;
`ifdef LSQ_MISALIGN_CHECK_EN
    if (e_init && mis(mq[n_iss])) e_init = 0;
    skip = n_iss == 0 && mq.size() > 0 && mis(mq[0]) && !halt_m && !clear_pipeline;
`endif
    e_ack = lsu_finished && n_iss != 0 && !clear_pipeline;
    chk("in_rdy", in_rdy, e_rdy);
    chk("lsu_initial", lsu_initial, e_init);
    chk("lsu_ack", lsu_ack, e_ack);
    chk("lsq_halt", lsq_halt, halt_m);
    chk("lsq_empty", lsq_empty, mq.size() == 0);
    if (e_init) begin
      chk("lsu_para", lsu_para, mq[n_iss].para);
      chk("lsu_addr", lsu_addr, mq[n_iss].addr);
      chk("lsu_wdata", lsu_wdata, mq[n_iss].wdata);
    end

    fire  = e_init && lsu_ready && !clear_pipeline;
    e_vld = 0;
    if (!rst) begin
      mq.delete(); lsu_q.delete(); n_iss = 0; halt_m = 0;
      e_rst = 1; e_we = 0; e_err = 0; e_rd = '0; e_data = '0;
    end else if (clear_pipeline) begin
      mq.delete(); lsu_q.delete(); n_iss = 0; halt_m = 0; e_rst = 0;
    end else begin
      e_rst = 0;
      if (e_ack) begin
        o      = mq.pop_front();
        is_st  = o.para[3];
        e_vld  = 1;
        e_rd   = o.rd;
        e_err  = lsu_status;
        e_data = is_st ? '0 : lsu_rdata;
        e_we   = !is_st && o.rd != 0 && !lsu_status;
        if (lsu_status) halt_m = 1;
        void'(lsu_q.pop_front());
        n_iss--;
      end else if (skip) begin
        o = mq.pop_front();
        e_vld = 1; e_rd = o.rd; e_err = 1; e_data = '0; e_we = 0;
        halt_m = 1;
      end
      if (fire) begin
        n_iss++;
        r.rdata = $urandom;
        r.st    = $urandom_range(99) < p_err;
        lsu_q.push_back(r);
      end
      if (in_vld && e_rdy) begin
        o.para = in_para; o.addr = in_addr; o.wdata = in_wdata; o.rd = in_rd;
        mq.push_back(o);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    e_rst = 1;
    //          vld rdy fin err clr rst spur
    repeat (400) step(60,  70,  60,  3,  2,  1,  3);
    repeat (200) step(90,  10,  50,  0,  1,  0,  0);
    repeat (300) step(60,  80,  70, 30,  6,  1,  3);
    repeat (300) step(70, 100, 100,  0,  1,  0,  0);
    repeat (300) step(50,  50,  40, 10,  3,  1,  5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
